// File: rtl/alu_pkg.sv
// Shared widths, operation codes and remainder-engine state encoding for the ALU.
package alu_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned MOD_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(MOD_ITER + 1);

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_XOR = 3'b010,
        ALU_NOR = 3'b011,
        ALU_LT  = 3'b100,
        ALU_ADD = 3'b101,
        ALU_SUB = 3'b110,
        ALU_MOD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        MOD_IDLE = 2'b00,
        MOD_BUSY = 2'b01,
        MOD_DONE = 2'b10
    } mod_state_e;

endpackage

// File: rtl/alu_mod_unit.sv
// Sequential unsigned remainder engine: restoring shift-subtract, one quotient bit per cycle.
module alu_mod_unit
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem,
    output logic             done
);

    mod_state_e       state;
    mod_state_e       state_nx;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MOD_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; one extra BUSY cycle after the last step lands done on edge 33
    always_comb begin
        state_nx = state;
        unique case (state)
            MOD_IDLE: if (start && sel)                state_nx = MOD_BUSY;
            MOD_BUSY: if (cnt == CNT_W'(MOD_ITER))     state_nx = MOD_DONE;
            MOD_DONE: if (!start)                      state_nx = MOD_IDLE;
            default:                                   state_nx = MOD_IDLE;
        endcase
    end

    // Restoring step; a negative trial keeps the shifted value (b==0 never subtracts anything)
    always_comb begin
        shifted  = {rem, dividend[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Datapath and done register
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state_nx == MOD_DONE);
            if (state == MOD_IDLE && start && sel) begin
                dividend <= a;
                divisor  <= b;
                rem      <= '0;
                cnt      <= '0;
            end else if (state == MOD_BUSY && cnt != CNT_W'(MOD_ITER)) begin
                dividend <= {dividend[WIDTH-2:0], 1'b0};
                rem      <= rem_step;
                cnt      <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational logic/compare/add/sub plus a multi-cycle unsigned MOD.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic [WIDTH-1:0] res,
    output logic             done,
    output logic             carry
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    alu_mod_unit u_mod (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sel   (aluop == ALU_MOD),
        .a     (a),
        .b     (b),
        .rem   (rem),
        .done  (done)
    );

    // Top bit of the widened difference is the unsigned borrow, i.e. a<b
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
    end

    always_comb begin
        res   = '0;
        carry = 1'b0;
        unique case (alu_op_e'(aluop))
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_NOR: res = ~(a | b);
            ALU_LT:  res = WIDTH'(diff[WIDTH]);
            ALU_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            ALU_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            ALU_MOD: res = rem;
            default: res = '0;
        endcase
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: table of combinational vectors plus hand-written MOD sequences.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  aluop;
    logic [31:0] res;
    logic        done;
    logic        carry;

    int checks   = 0;
    int failures = 0;

    alu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .aluop (aluop),
        .res   (res),
        .done  (done),
        .carry (carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_res;
        logic        exp_carry;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Launch a MOD, scramble inputs while busy, then check latency, result, hold and release
    task automatic run_mod(input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] exp);
        int n;
        @(negedge clk);
        a = ma; b = mb; aluop = 3'b111; start = 1'b1;
        @(posedge clk);
        #1;
        a = ~ma; b = mb + 32'd3; aluop = 3'b000;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk("mod_latency", 32'(n), 32'd33);
        aluop = 3'b111;
        #1;
        chk("mod_res", res, exp);
        repeat (3) @(posedge clk);
        #1;
        chk("mod_hold_done", 32'(done), 32'd1);
        chk("mod_hold_res", res, exp);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("mod_idle_done", 32'(done), 32'd0);
        chk("mod_keep_res", res, exp);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'hFFAADD16, 32'hABCD0012, 32'hAB880012, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFAADD16, 32'hABCD0012, 32'hFFEFDD16, 1'b0};
        vecs[2]  = '{3'b010, 32'hFFAADD16, 32'hABCD0012, 32'h5467DD04, 1'b0};
        vecs[3]  = '{3'b011, 32'hFFAADD16, 32'hABCD0012, 32'h001022E9, 1'b0};
        vecs[4]  = '{3'b100, 32'hABCD0012, 32'hFFAADD16, 32'h00000001, 1'b0};
        vecs[5]  = '{3'b100, 32'hFFAADD16, 32'hABCD0012, 32'h00000000, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFAADD16, 32'hABCD0012, 32'hAB77DD28, 1'b1};
        vecs[7]  = '{3'b110, 32'hFFAADD16, 32'hABCD0012, 32'h53DDDD04, 1'b0};
        vecs[8]  = '{3'b110, 32'hABCD0012, 32'hFFAADD16, 32'hAC2222FC, 1'b1};
        vecs[9]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[10] = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        vecs[11] = '{3'b100, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; aluop = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rem", res, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].va; b = vecs[i].vb; aluop = vecs[i].op;
            #1;
            chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
        end

        run_mod(32'd22, 32'd6, 32'd4);
        run_mod(32'd1234, 32'd0, 32'd1234);
        run_mod(32'hFFFFFFFF, 32'd7, 32'd3);
        run_mod(32'd5, 32'd9, 32'd5);
        run_mod(32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF);
        run_mod(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);

        // start with a non-MOD op must never launch the engine
        @(negedge clk);
        a = 32'd100; b = 32'd7; aluop = 3'b101; start = 1'b1;
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            chk("ignored_start_done", 32'(seen), 32'd0);
        end
        @(negedge clk);
        start = 1'b0; aluop = 3'b111;
        #1;
        chk("ignored_start_rem", res, 32'd0);

        // reset in the middle of BUSY, with start still high on the reset edge
        @(negedge clk);
        a = 32'd100; b = 32'd7; aluop = 3'b111; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_rem", res, 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            chk("midreset_idle", 32'(seen), 32'd0);
        end
        run_mod(32'd100, 32'd7, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
